// File: rtl/stage1_recomb.sv
// Hyperbolic argument recombination: applies k steps of +0.5 to sinh/cosh.
// Ports: clk, rst, iValid/iReady in, oValid/oReady out, iSinh/iCosh/iSteps/iSign, sinhOut/coshOut.
package stage1_recomb_pkg;
  localparam int IDWIDTH     = 16;
  localparam int I_FRA_WIDTH = 12;
endpackage

module stage1_recomb
  import stage1_recomb_pkg::*;
#(
  parameter int DWIDTH    = IDWIDTH,
  parameter int FRA_WIDTH = I_FRA_WIDTH,
  parameter int KWIDTH    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iValid,
  output logic              iReady,
  input  logic [DWIDTH-1:0] iSinh,
  input  logic [DWIDTH-1:0] iCosh,
  input  logic [KWIDTH-1:0] iSteps,
  input  logic              iSign,
  output logic              oValid,
  input  logic              oReady,
  output logic [DWIDTH-1:0] sinhOut,
  output logic [DWIDTH-1:0] coshOut
);

  // Guard bits keep every intermediate exact; only the final sum saturates.
  localparam int W = DWIDTH + 4;

  localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};

  if (FRA_WIDTH >= DWIDTH) begin : g_bad_fmt
    $error("FRA_WIDTH must leave room for integer bits");
  end

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] s_q, s_d;
  logic [DWIDTH-1:0] c_q, c_d;
  logic [KWIDTH-1:0] cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [DWIDTH-1:0] sh_q, sh_d;
  logic [DWIDTH-1:0] ch_q, ch_d;

  logic signed [W-1:0] sx;
  logic signed [W-1:0] cx;

  // x * sinh(0.5)
  function automatic logic signed [W-1:0] f_s(
    input logic signed [W-1:0] x
  );
    logic signed [W-1:0] a, b, d;
    a = x + (x >>> 2);
    b = (a >>> 4) + (x >>> 6);
    d = ((a + b) >>> 5) + x;
    return d >>> 1;
  endfunction

  // x * cosh(0.5)
  function automatic logic signed [W-1:0] f_c(
    input logic signed [W-1:0] x
  );
    return x + (x >>> 3) + (x >>> 9) + (x >>> 11);
  endfunction

  // Overflow whenever the guard bits disagree with the result sign bit.
  function automatic logic [DWIDTH-1:0] sat(
    input logic signed [W-1:0] v
  );
    logic [DWIDTH-1:0] r;
    r = v[DWIDTH-1:0];
    if (v[W-1] && !(&v[W-2:DWIDTH-1]))
      r = MINV;
    else if (!v[W-1] && (|v[W-2:DWIDTH-1]))
      r = MAXV;
    return r;
  endfunction

  assign sx = {{(W-DWIDTH){s_q[DWIDTH-1]}}, s_q};
  assign cx = {{(W-DWIDTH){c_q[DWIDTH-1]}}, c_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    sh_d    = sh_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          s_d     = iSinh;
          c_d     = iCosh;
          cnt_d   = iSteps;
          sign_d  = iSign;
          state_d = ITER;
        end
      end
      ITER: begin
        if (cnt_q != '0) begin
          s_d   = sat(f_s(cx) + f_c(sx));
          c_d   = sat(f_c(cx) + f_s(sx));
          cnt_d = cnt_q - KWIDTH'(1);
        end else begin
          // -MIN saturates to MAX through sat()
          sh_d    = sign_q ? sat(-sx) : s_q;
          ch_d    = c_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (oReady)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      sh_q    <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      sh_q    <= sh_d;
      ch_q    <= ch_d;
    end
  end

  assign iReady  = (state_q == IDLE);
  assign oValid  = (state_q == DONE);
  assign sinhOut = sh_q;
  assign coshOut = ch_q;

endmodule

// File: tb/tb_stage1_recomb.sv
// Bench for stage1_recomb: directed vectors, stall, reset and random ops.
// Random ops are checked against an integer model of the recombination.
module tb_stage1_recomb;

  logic        clk = 1'b0;
  logic        rst;
  logic        iValid;
  logic        iReady;
  logic [15:0] iSinh;
  logic [15:0] iCosh;
  logic [2:0]  iSteps;
  logic        iSign;
  logic        oValid;
  logic        oReady;
  logic [15:0] sinhOut;
  logic [15:0] coshOut;

  int n_chk  = 0;
  int n_fail = 0;

  stage1_recomb #(
    .DWIDTH(16),
    .FRA_WIDTH(12),
    .KWIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iValid(iValid),
    .iReady(iReady),
    .iSinh(iSinh),
    .iCosh(iCosh),
    .iSteps(iSteps),
    .iSign(iSign),
    .oValid(oValid),
    .oReady(oReady),
    .sinhOut(sinhOut),
    .coshOut(coshOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int m_s(int x);
    int a, b, d;
    a = x + (x >>> 2);
    b = (a >>> 4) + (x >>> 6);
    d = ((a + b) >>> 5) + x;
    return d >>> 1;
  endfunction

  function automatic int m_c(int x);
    return x + (x >>> 3) + (x >>> 9) + (x >>> 11);
  endfunction

  task automatic model(input logic [15:0] s0, input logic [15:0] c0,
                       input int k, input logic sg,
                       output logic [15:0] so, output logic [15:0] co);
    int s, c, ns, nc;
    s = int'($signed(s0));
    c = int'($signed(c0));
    for (int i = 0; i < k; i++) begin
      ns = sat16(m_s(c) + m_c(s));
      nc = sat16(m_c(c) + m_s(s));
      s = ns;
      c = nc;
    end
    so = 16'(sg ? sat16(-s) : s);
    co = 16'(c);
  endtask

  // Offers one operand, then keeps iValid high with junk until oValid.
  // lat counts edges from the acceptance edge inclusive; -1 on timeout.
  task automatic send(input logic [15:0] s, input logic [15:0] c,
                      input logic [2:0] k, input logic sg,
                      output int lat);
    iValid = 1'b1;
    iSinh  = s;
    iCosh  = c;
    iSteps = k;
    iSign  = sg;
    @(posedge clk);
    #1;
    lat = 1;
    while (!oValid && lat < 40) begin
      iSinh  = 16'($urandom);
      iCosh  = 16'($urandom);
      iSteps = 3'($urandom);
      iSign  = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    iValid = 1'b0;
    if (!oValid) lat = -1;
  endtask

  task automatic release_out();
    oReady = 1'b1;
    @(posedge clk);
    #1;
    oReady = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    iValid = 1'b0;
    oReady = 1'b0;
    iSinh  = '0;
    iCosh  = '0;
    iSteps = '0;
    iSign  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (iReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_iReady got %b want 1", iReady);
    end
    n_chk++;
    if (oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_oValid got %b want 0", oValid);
    end
    n_chk++;
    if (sinhOut !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_sinh got %h want 0000", sinhOut);
    end
    n_chk++;
    if (coshOut !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_cosh got %h want 0000", coshOut);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] vs[4]  = '{16'h0000, 16'h0000, 16'h0400, 16'h0000};
    logic [15:0] vc[4]  = '{16'h1000, 16'h1000, 16'h1100, 16'h1000};
    logic [2:0]  vk[4]  = '{3'd1, 3'd1, 3'd0, 3'd7};
    logic        vg[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] es[4]  = '{16'h0856, 16'hF7AA, 16'h0400, 16'h7FFF};
    logic [15:0] ec[4]  = '{16'h120A, 16'h120A, 16'h1100, 16'h7FFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(vs[i], vc[i], vk[i], vg[i], lat);
      n_chk++;
      if (lat !== int'(vk[i]) + 2) begin
        n_fail++;
        $display("FAIL vec%0d_lat got %0d want %0d", i, lat, vk[i] + 2);
      end
      n_chk++;
      if (sinhOut !== es[i]) begin
        n_fail++;
        $display("FAIL vec%0d_sinh got %h want %h", i, sinhOut, es[i]);
      end
      n_chk++;
      if (coshOut !== ec[i]) begin
        n_fail++;
        $display("FAIL vec%0d_cosh got %h want %h", i, coshOut, ec[i]);
      end
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [15:0] es, ec;
    int lat;
    model(16'h0200, 16'h1080, 2, 1'b1, es, ec);
    send(16'h0200, 16'h1080, 3'd2, 1'b1, lat);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL stall_lat got %0d want 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      iValid = 1'b1;
      iSinh  = 16'($urandom);
      iCosh  = 16'($urandom);
      iSteps = 3'($urandom);
      @(posedge clk);
      #1;
      n_chk++;
      if (oValid !== 1'b1 || iReady !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hs c%0d got v=%b r=%b want 1 0",
                 i, oValid, iReady);
      end
      n_chk++;
      if (sinhOut !== es || coshOut !== ec) begin
        n_fail++;
        $display("FAIL stall_hold c%0d got %h %h want %h %h",
                 i, sinhOut, coshOut, es, ec);
      end
    end
    iValid = 1'b0;
    release_out();
    n_chk++;
    if (iReady !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release got r=%b v=%b want 1 0",
               iReady, oValid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (iReady !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ignored got r=%b want 1", iReady);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    iValid = 1'b1;
    iSinh  = 16'h0100;
    iCosh  = 16'h1000;
    iSteps = 3'd5;
    iSign  = 1'b0;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (iReady !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy got r=%b want 0", iReady);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_chk++;
    if (iReady !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_hs got r=%b v=%b want 1 0", iReady, oValid);
    end
    n_chk++;
    if (sinhOut !== 16'h0 || coshOut !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst_out got %h %h want 0 0", sinhOut, coshOut);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (oValid) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_no_result got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_rst_priority();
    int lat;
    iValid = 1'b1;
    iSinh  = 16'h0300;
    iCosh  = 16'h1200;
    iSteps = 3'd0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    iValid = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (iReady !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_valid got r=%b v=%b want 1 0", iReady, oValid);
    end
    send(16'h0300, 16'h1200, 3'd0, 1'b0, lat);
    n_chk++;
    if (sinhOut !== 16'h0300 || lat !== 2) begin
      n_fail++;
      $display("FAIL prio_op got %h lat %0d want 0300 lat 2",
               sinhOut, lat);
    end
    oReady = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    oReady = 1'b0;
    rst    = 1'b0;
    n_chk++;
    if (sinhOut !== 16'h0 || coshOut !== 16'h0 || iReady !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_ready got %h %h r=%b want 0 0 1",
               sinhOut, coshOut, iReady);
    end
  endtask

  task automatic test_random();
    logic [15:0] s, c, es, ec;
    logic [2:0]  k;
    logic        sg;
    int lat;
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) begin
        s = 16'($urandom);
        c = 16'($urandom);
      end else begin
        s = 16'($signed(12'($urandom)));
        c = 16'($urandom_range(4096, 8191));
      end
      k  = 3'($urandom);
      sg = 1'($urandom);
      if (i == 5) begin
        s  = 16'h8000;
        k  = 3'd0;
        sg = 1'b1;
      end
      model(s, c, int'(k), sg, es, ec);
      send(s, c, k, sg, lat);
      n_chk++;
      if (lat !== int'(k) + 2) begin
        n_fail++;
        $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, k + 2);
      end
      n_chk++;
      if (sinhOut !== es || coshOut !== ec) begin
        n_fail++;
        $display("FAIL rnd%0d_out in %h %h k%0d s%b got %h %h want %h %h",
                 i, s, c, k, sg, sinhOut, coshOut, es, ec);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_rst_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
